// File: rtl/dma_regfile_pkg.sv
// Shared definitions for the DMA channel register file.
//   - Offset helpers: the CPU register map is a function of the channel count.
//   - Mode layout: the stored mode is cpu_wdata[7:2]. Bit 5 selects address
//     decrement and bit 4 selects autoinitialize.
//   - Command and status bit positions.
package dma_regfile_pkg;

  localparam int DEC_BIT      = 5;
  localparam int AUTOINIT_BIT = 4;

  localparam int STAT_TC_LSB  = 0;
  localparam int STAT_REQ_LSB = 4;

  typedef struct packed {
    logic       dec;       // [5] address decrement
    logic       autoinit;  // [4] reload base registers on TC
    logic [3:0] misc;      // [3:0] passed through to the timing FSM
  } mode_t;

  typedef struct packed {
    logic dack_hi;    // [7]
    logic dreq_lo;    // [6]
    logic ext_wr;     // [5]
    logic rot_pri;    // [4]
    logic compr_tim;  // [3]
    logic ctrl_dis;   // [2]
    logic ch0_hold;   // [1]
    logic mem2mem;    // [0]
  } cmd_t;

  function automatic int off_cmd   (int n); return 2*n;     endfunction
  function automatic int off_stat  (int n); return 2*n + 1; endfunction
  function automatic int off_mask  (int n); return 2*n + 2; endfunction
  function automatic int off_mode  (int n); return 2*n + 3; endfunction
  function automatic int off_clrbp (int n); return 2*n + 4; endfunction
  function automatic int off_mclr  (int n); return 2*n + 5; endfunction
  function automatic int off_clrmsk(int n); return 2*n + 6; endfunction
  function automatic int off_allmsk(int n); return 2*n + 7; endfunction

endpackage

// File: rtl/dma_channel_regfile_byte_ptr.sv
// Byte pointer shared by all multi-byte address and count accesses.
// The pointer counts 0..NB-1 and then wraps back to 0. Clear has priority
// over advance.
// Ports:
//   clk, resetN : clock and synchronous active-low reset
//   clr_i       : force the pointer to 0
//   adv_i       : advance the pointer after a byte access
//   bp_o        : current byte index
module dma_byte_ptr #(
  parameter  int NB   = 2,
  localparam int BP_W = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic            clk,
  input  logic            resetN,
  input  logic            clr_i,
  input  logic            adv_i,
  output logic [BP_W-1:0] bp_o
);

  logic [BP_W-1:0] bp_q;

  always_ff @(posedge clk) begin
    if (!resetN || clr_i)
      bp_q <= '0;
    else if (adv_i)
      bp_q <= (bp_q == BP_W'(NB-1)) ? '0 : bp_q + BP_W'(1);
  end

  assign bp_o = bp_q;

endmodule

// File: rtl/dma_channel_regfile.sv
// Register file for a DMA channel. The CPU programs it byte-serially over an
// 8-bit port. The transfer side updates the address and count registers,
// detects terminal count, performs autoinit reload and sets the mask on TC.
// Optional macro: DMA_SW_REQ_EN enables the software request register.
// Ports:
//   clk, resetN          : clock and synchronous active-low reset
//   cpu_wr/cpu_rd        : single-cycle CPU strobes
//   cpu_addr/cpu_wdata   : register offset and write data
//   cpu_rdata            : registered read data, held until the next read
//   xfer_step/xfer_ch    : one completed transfer on the channel xfer_ch
//   cur_addr_o/cur_count_o/mode_o : live view of channel xfer_ch
//   command_o, mask_o, sw_req_o   : control state
//   tc_o                 : one-cycle terminal-count pulse
module dma_channel_regfile import dma_regfile_pkg::*; #(
  parameter  int NUM_CH = 4,
  parameter  int REG_W  = 16,
  localparam int NB     = REG_W/8,
  localparam int A_W    = $clog2(2*NUM_CH+8),
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              cpu_wr,
  input  logic              cpu_rd,
  input  logic [A_W-1:0]    cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  input  logic              xfer_step,
  input  logic [CH_W-1:0]   xfer_ch,
  output logic [REG_W-1:0]  cur_addr_o,
  output logic [REG_W-1:0]  cur_count_o,
  output logic [5:0]        mode_o,
  output logic [7:0]        command_o,
  output logic [NUM_CH-1:0] mask_o,
  output logic [NUM_CH-1:0] sw_req_o,
  output logic              tc_o
);

  localparam int BP_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [31:0] OFF_CMD    = 32'(off_cmd(NUM_CH));
  localparam logic [31:0] OFF_STAT   = 32'(off_stat(NUM_CH));
  localparam logic [31:0] OFF_MASK   = 32'(off_mask(NUM_CH));
  localparam logic [31:0] OFF_MODE   = 32'(off_mode(NUM_CH));
  localparam logic [31:0] OFF_CLRBP  = 32'(off_clrbp(NUM_CH));
  localparam logic [31:0] OFF_MCLR   = 32'(off_mclr(NUM_CH));
  localparam logic [31:0] OFF_CLRMSK = 32'(off_clrmsk(NUM_CH));
  localparam logic [31:0] OFF_ALLMSK = 32'(off_allmsk(NUM_CH));

  logic [NUM_CH-1:0][REG_W-1:0] base_addr_q, base_addr_d, cur_addr_q, cur_addr_d;
  logic [NUM_CH-1:0][REG_W-1:0] base_cnt_q, base_cnt_d, cur_cnt_q, cur_cnt_d;
  mode_t [NUM_CH-1:0]           mode_q, mode_d;
  cmd_t                         command_q, command_d;
  logic [NUM_CH-1:0]            mask_q, mask_d, req_q, req_d, tcf_q, tcf_d;
  logic [7:0]                   rdata_q, rdata_d;
  logic                         tc_q, tc_d;

  logic [BP_W-1:0]   bp;
  logic [31:0]       off;
  logic              rd_en, rw_reg, mclr, bp_clr;
  logic [NUM_CH-1:0] wr_hit;
  int                bsel;

  // A write wins over a read in the same cycle. Master clear behaves exactly
  // like reset, so it is folded into the reset term of the register process.
  always_comb begin
    off    = 32'(cpu_addr);
    rd_en  = cpu_rd & ~cpu_wr;
    rw_reg = (cpu_wr | rd_en) && (off < OFF_CMD);
    mclr   = cpu_wr && (off == OFF_MCLR);
    bp_clr = cpu_wr && (off == OFF_CLRBP);
    bsel   = 8*int'(bp);
  end

  dma_byte_ptr #(.NB(NB)) u_bp (
    .clk    (clk),
    .resetN (resetN),
    .clr_i  (bp_clr | mclr),
    .adv_i  (rw_reg),
    .bp_o   (bp)
  );

  always_comb begin
    base_addr_d = base_addr_q;
    cur_addr_d  = cur_addr_q;
    base_cnt_d  = base_cnt_q;
    cur_cnt_d   = cur_cnt_q;
    mode_d      = mode_q;
    command_d   = command_q;
    mask_d      = mask_q;
    req_d       = req_q;
    tcf_d       = tcf_q;
    rdata_d     = rdata_q;
    tc_d        = 1'b0;
    wr_hit      = '0;

    // CPU writes are applied first, so TC effects below override them.
    for (int c = 0; c < NUM_CH; c++) begin
      wr_hit[c] = cpu_wr && (off < OFF_CMD) && (off[31:1] == 31'(c));
      if (wr_hit[c]) begin
        if (!off[0]) begin
          base_addr_d[c][bsel +: 8] = cpu_wdata;
          cur_addr_d[c][bsel +: 8]  = cpu_wdata;
        end else begin
          base_cnt_d[c][bsel +: 8] = cpu_wdata;
          cur_cnt_d[c][bsel +: 8]  = cpu_wdata;
        end
      end
      if (cpu_wr && cpu_wdata[1:0] == 2'(c)) begin
        if (off == OFF_MASK) mask_d[c] = cpu_wdata[2];
        if (off == OFF_MODE) mode_d[c] = mode_t'(cpu_wdata[7:2]);
`ifdef DMA_SW_REQ_EN
        if (off == OFF_STAT) req_d[c] = cpu_wdata[2];
`endif
      end
    end
    if (cpu_wr && off == OFF_CMD)    command_d = cmd_t'(cpu_wdata);
    if (cpu_wr && off == OFF_CLRMSK) mask_d    = '0;
    if (cpu_wr && off == OFF_ALLMSK) mask_d    = cpu_wdata[NUM_CH-1:0];

    // The status read clears the flags before new TCs are merged in, so a
    // TC in the same cycle survives the read.
    if (rd_en && off == OFF_STAT) tcf_d = '0;

    // A CPU write to the stepping channel's address or count drops the
    // step entirely.
    for (int c = 0; c < NUM_CH; c++) begin
      if (xfer_step && 32'(xfer_ch) == 32'(c) && !wr_hit[c]) begin
        cur_addr_d[c] = mode_q[c][DEC_BIT] ? cur_addr_q[c] - REG_W'(1)
                                           : cur_addr_q[c] + REG_W'(1);
        cur_cnt_d[c]  = cur_cnt_q[c] - REG_W'(1);
        if (cur_cnt_q[c] == '0) begin
          tc_d     = 1'b1;
          tcf_d[c] = 1'b1;
          req_d[c] = 1'b0;
          if (mode_q[c][AUTOINIT_BIT]) begin
            cur_addr_d[c] = base_addr_q[c];
            cur_cnt_d[c]  = base_cnt_q[c];
          end else begin
            mask_d[c] = 1'b1;
          end
        end
      end
    end

    if (rd_en) begin
      rdata_d = 8'h00;
      if (off < OFF_CMD) begin
        for (int c = 0; c < NUM_CH; c++)
          if (off[31:1] == 31'(c))
            rdata_d = off[0] ? cur_cnt_q[c][bsel +: 8] : cur_addr_q[c][bsel +: 8];
      end else if (off == OFF_STAT) begin
        for (int j = 0; j < NUM_CH; j++) begin
          rdata_d[STAT_TC_LSB+j]  = tcf_q[j];
          rdata_d[STAT_REQ_LSB+j] = req_q[j];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN || mclr) begin
      base_addr_q <= '0;
      cur_addr_q  <= '0;
      base_cnt_q  <= '0;
      cur_cnt_q   <= '0;
      mode_q      <= '0;
      command_q   <= '0;
      mask_q      <= '1;
      req_q       <= '0;
      tcf_q       <= '0;
      rdata_q     <= '0;
      tc_q        <= 1'b0;
    end else begin
      base_addr_q <= base_addr_d;
      cur_addr_q  <= cur_addr_d;
      base_cnt_q  <= base_cnt_d;
      cur_cnt_q   <= cur_cnt_d;
      mode_q      <= mode_d;
      command_q   <= command_d;
      mask_q      <= mask_d;
      req_q       <= req_d;
      tcf_q       <= tcf_d;
      rdata_q     <= rdata_d;
      tc_q        <= tc_d;
    end
  end

  // Live view of the active channel. Out-of-range channels read as zero.
  always_comb begin
    cur_addr_o  = '0;
    cur_count_o = '0;
    mode_o      = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (32'(xfer_ch) == 32'(c)) begin
        cur_addr_o  = cur_addr_q[c];
        cur_count_o = cur_cnt_q[c];
        mode_o      = mode_q[c];
      end
    end
  end

  assign cpu_rdata = rdata_q;
  assign command_o = command_q;
  assign mask_o    = mask_q;
  assign tc_o      = tc_q;
`ifdef DMA_SW_REQ_EN
  assign sw_req_o  = req_q;
`else
  assign sw_req_o  = '0;
`endif

endmodule
